// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Sequential restoring divider for DIV/IDIV. It produces one quotient bit per
// clock and sits beside the ALU. The microcode sequencer stalls while busy is
// high, then writes {rem,quo} back to DX:AX (word) or AH:AL (byte).
// Divide-by-zero and quotient overflow raise div_exc, so the core can vector
// to INT 0.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   operation request, sampled only while idle
//   x        in   32  dividend: word = DX:AX, byte = x[15:0]
//   y        in   16  divisor: word = y, byte = y[7:0]
//   word_op  in   1   1 = 16-bit operation, 0 = 8-bit operation
//   sign_op  in   1   1 = IDIV, 0 = DIV
//   busy     out  1   high while iterating and fixing up
//   done     out  1   one-cycle pulse; o and div_exc are valid in that cycle
//   o        out  32  word: {rem,quo}; byte: {16'h0,rem[7:0],quo[7:0]}
//   div_exc  out  1   1 = divide error (#DE); o is forced to 0
// ---------------------------------------------------------------------------
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [15:0] y,
  input  logic        word_op,
  input  logic        sign_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] o,
  output logic        div_exc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched operation context
  logic [15:0] r_rem;
  logic [15:0] r_lo;
  logic [15:0] r_quo;
  logic [15:0] r_dvs;
  logic [4:0]  r_count;
  logic        r_word;
  logic        r_sign;
  logic        r_quoNeg;
  logic        r_remNeg;
  logic [31:0] r_o;
  logic        r_exc;

  // Operand magnitudes, computed from the live inputs in the start cycle
  logic        w_sx;
  logic        w_sy;
  logic [31:0] w_xMag;
  logic [15:0] w_yMag;
  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic        w_earlyExc;
  logic        w_load;

  // Iteration step
  logic [16:0] w_part;
  logic [16:0] w_diff;
  logic        w_borrow;

  // Fix-up results
  logic [15:0] w_quoFix;
  logic [15:0] w_remFix;
  logic [15:0] w_limit;
  logic        w_ovf;
  logic [31:0] w_fixO;

  assign w_sx = word_op ? x[31] : x[15];
  assign w_sy = word_op ? y[15] : y[7];

  // The negation of -2^31 wraps back to 0x8000_0000. That is the correct
  // unsigned magnitude, so no extra bit is needed.
  always_comb begin
    w_xMag = word_op ? x : {16'h0, x[15:0]};
    w_yMag = word_op ? y : {8'h0, y[7:0]};
    if (sign_op && w_sx) begin
      w_xMag = word_op ? (~x + 32'd1) : {16'h0, (~x[15:0] + 16'd1)};
    end
    if (sign_op && w_sy) begin
      w_yMag = word_op ? (~y + 16'd1) : {8'h0, (~y[7:0] + 8'd1)};
    end
  end

  // The high half of the dividend seeds the partial remainder. The low half
  // is left-aligned, so its next bit is always r_lo[15]. If the high half is
  // not below the divisor, the quotient cannot fit in N bits. This check also
  // catches a zero divisor.
  assign w_hi       = word_op ? w_xMag[31:16] : {8'h0, w_xMag[15:8]};
  assign w_lo       = word_op ? w_xMag[15:0]  : {w_xMag[7:0], 8'h0};
  assign w_earlyExc = (w_hi >= w_yMag);
  assign w_load     = (r_state == S_IDLE) && start;

  // The trial subtraction uses N+1 bits. The remainder is always below the
  // divisor, so bit 16 of the difference is set only when a borrow occurs.
  assign w_part   = {r_rem, r_lo[15]};
  assign w_diff   = w_part - {1'b0, r_dvs};
  assign w_borrow = w_diff[16];

  assign w_quoFix = r_quoNeg ? (~r_quo + 16'd1) : r_quo;
  assign w_remFix = r_remNeg ? (~r_rem + 16'd1) : r_rem;

  // A negative quotient may reach 2^(N-1). A positive quotient must stay
  // below 2^(N-1).
  always_comb begin
    if (r_quoNeg) begin
      w_limit = r_word ? 16'h8000 : 16'h0080;
    end else begin
      w_limit = r_word ? 16'h7FFF : 16'h007F;
    end
  end

  assign w_ovf  = r_sign && (r_quo > w_limit);
  assign w_fixO = w_ovf  ? 32'h0 :
                  r_word ? {w_remFix, w_quoFix} :
                           {16'h0, w_remFix[7:0], w_quoFix[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_earlyExc ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_count == 5'd1) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= 16'h0;
      r_lo     <= 16'h0;
      r_quo    <= 16'h0;
      r_dvs    <= 16'h0;
      r_count  <= 5'd0;
      r_word   <= 1'b0;
      r_sign   <= 1'b0;
      r_quoNeg <= 1'b0;
      r_remNeg <= 1'b0;
      r_o      <= 32'h0;
      r_exc    <= 1'b0;
    end else begin
      if (w_load) begin
        r_rem    <= w_hi;
        r_lo     <= w_lo;
        r_quo    <= 16'h0;
        r_dvs    <= w_yMag;
        r_count  <= word_op ? 5'd16 : 5'd8;
        r_word   <= word_op;
        r_sign   <= sign_op;
        r_quoNeg <= sign_op && (w_sx ^ w_sy);
        r_remNeg <= sign_op && w_sx;
        if (w_earlyExc) begin
          r_o   <= 32'h0;
          r_exc <= 1'b1;
        end
      end else if (r_state == S_ITER) begin
        r_rem   <= w_borrow ? w_part[15:0] : w_diff[15:0];
        r_lo    <= {r_lo[14:0], 1'b0};
        r_quo   <= {r_quo[14:0], ~w_borrow};
        r_count <= r_count - 5'd1;
      end else if (r_state == S_FIX) begin
        r_o   <= w_fixO;
        r_exc <= w_ovf;
      end
    end
  end

  assign o       = r_o;
  assign div_exc = r_exc;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
// Directed testbench for div_seq. Each vector has a hand-computed result,
// exception flag and done cycle. It also covers start pulses while busy and
// a reset asserted in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = 32'h0;
  logic [15:0] y = 16'h0;
  logic        word_op = 1'b0;
  logic        sign_op = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] o;
  logic        div_exc;

  int checkCount = 0;
  int failCount  = 0;

  div_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .word_op (word_op),
    .sign_op (sign_op),
    .busy    (busy),
    .done    (done),
    .o       (o),
    .div_exc (div_exc)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Guard against a hang anywhere in the sequence
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  // Every comparison goes through this task. It counts the comparison and
  // reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present an operation for one cycle so that it is accepted at edge E0.
  // Afterwards, scramble the operand and mode inputs so that any design
  // that keeps reading them after E0 is caught.
  task automatic applyStimulus(input logic [31:0] xv, input logic [15:0] yv,
                               input logic wordOp, input logic signOp);
    @(negedge clk);
    x       = xv;
    y       = yv;
    word_op = wordOp;
    sign_op = signOp;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    x       = ~xv;
    y       = ~yv;
    word_op = ~wordOp;
    sign_op = ~signOp;
  endtask

  // Run one operation and check its result, done cycle and busy window, and
  // that the outputs hold after the done pulse. Set pulseAt to a nonzero
  // cycle number to pulse a stray start (with a zero divisor) in that cycle.
  task automatic runOp(input string tag, input logic [31:0] xv, input logic [15:0] yv,
                       input logic wordOp, input logic signOp, input logic [31:0] expO,
                       input logic expExc, input int expCycle, input int pulseAt);
    int cyc;
    int doneCycle;
    int busyCycles;
    applyStimulus(xv, yv, wordOp, signOp);
    cyc        = 1;
    doneCycle  = -1;
    busyCycles = 0;
    while (cyc <= 40 && doneCycle < 0) begin
      if (done) begin
        doneCycle = cyc;
        checkOutput({tag, "/busyAtDone"}, {31'h0, busy}, 32'h0);
      end else begin
        if (busy) busyCycles++;
        if (cyc == pulseAt) begin
          start = 1'b1;
          x     = 32'h0;
          y     = 16'h0;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    checkOutput({tag, "/doneCycle"}, doneCycle, expCycle);
    checkOutput({tag, "/o"}, o, expO);
    checkOutput({tag, "/exc"}, {31'h0, div_exc}, {31'h0, expExc});
    checkOutput({tag, "/busyCycles"}, busyCycles, expCycle - 1);
    if (doneCycle > 0) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "/donePulse"}, {31'h0, done}, 32'h0);
      checkOutput({tag, "/oHold"}, o, expO);
      checkOutput({tag, "/excHold"}, {31'h0, div_exc}, {31'h0, expExc});
    end
  endtask

  // Main sequence: check the reset state, then the directed vectors, then
  // the abort-by-reset case
  initial begin
    int doneSeen;
    int busySeen;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/busy", {31'h0, busy}, 32'h0);
    checkOutput("reset/done", {31'h0, done}, 32'h0);
    checkOutput("reset/o", o, 32'h0);
    checkOutput("reset/exc", {31'h0, div_exc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("wordDiv",       32'h0001_0000, 16'h0002, 1'b1, 1'b0, 32'h0000_8000, 1'b0, 18, 0);
    runOp("byteDiv",       32'h0000_0064, 16'h0007, 1'b0, 1'b0, 32'h0000_020E, 1'b0, 10, 0);
    runOp("wordDivZero",   32'h1234_5678, 16'h0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1,  0);
    runOp("byteDivZero",   32'h0000_0064, 16'h0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1,  0);
    runOp("wordDivOvf",    32'h0005_0000, 16'h0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1,  0);
    runOp("wordDivMixed",  32'h1234_5678, 16'hABCD, 1'b1, 1'b0, 32'h3DD8_1B20, 1'b0, 18, 0);
    runOp("byteDivHiIgn",  32'hABCD_00FF, 16'h1210, 1'b0, 1'b0, 32'h0000_0F0F, 1'b0, 10, 0);
    runOp("wordIdivNeg",   32'hFFFF_FFF9, 16'h0002, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 18, 0);
    runOp("byteIdivNegY",  32'h0000_0007, 16'h00FE, 1'b0, 1'b1, 32'h0000_01FD, 1'b0, 10, 0);
    runOp("byteIdivNegX",  32'h0000_FFF9, 16'h0002, 1'b0, 1'b1, 32'h0000_FFFD, 1'b0, 10, 0);
    runOp("wordIdivPosOv", 32'h0000_8000, 16'h0001, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 18, 0);
    runOp("wordIdivMinQ",  32'hFFFF_8000, 16'h0001, 1'b1, 1'b1, 32'h0000_8000, 1'b0, 18, 0);
    runOp("byteIdivMinQ",  32'h0000_FF80, 16'h0001, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 10, 0);
    runOp("wordIdivNegOv", 32'hFFFF_7FFF, 16'h0001, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 18, 0);
    runOp("wordIdivMin32", 32'h8000_0000, 16'h8000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1,  0);
    runOp("startIgnored",  32'h0001_0000, 16'h0002, 1'b1, 1'b0, 32'h0000_8000, 1'b0, 18, 5);

    // Abort a word operation partway through ITER. Outputs must clear at
    // once, and no done pulse may follow.
    applyStimulus(32'h1234_5678, 16'hABCD, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort/busy", {31'h0, busy}, 32'h0);
    checkOutput("abort/done", {31'h0, done}, 32'h0);
    checkOutput("abort/o", o, 32'h0);
    checkOutput("abort/exc", {31'h0, div_exc}, 32'h0);
    doneSeen = 0;
    busySeen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
      if (busy) busySeen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
      if (busy) busySeen++;
    end
    checkOutput("abort/noDone", doneSeen, 0);
    checkOutput("abort/noBusy", busySeen, 0);

    runOp("afterAbort",    32'h0000_0064, 16'h0007, 1'b0, 1'b0, 32'h0000_020E, 1'b0, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
